// File: rtl/bf16_pkg.sv
// Shared BF16 field widths, exception encodings, divider state enum and operand unpack helper.
package bf16_pkg;

    localparam int EXP_W        = 8;
    localparam int MANT_W       = 7;
    localparam int EXP_BIAS_DEF = 127;

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expn;
        logic [MANT_W:0]   mant;   // {hidden 1, fraction}
    } bf16_fields_t;

    function automatic bf16_fields_t bf16_unpack(input logic [15:0] x);
        bf16_fields_t f;
        f.sign = x[15];
        f.expn = x[14:7];
        f.mant = {1'b1, x[6:0]};
        return f;
    endfunction

endpackage

// File: rtl/bf16_div_step.sv
// One restoring division step: conditional subtract of the divisor mantissa, then shift left.
module bf16_div_step (
    input  logic [8:0] r,
    input  logic [7:0] mb,
    output logic [8:0] r_next,
    output logic       q_bit
);

    logic [8:0] diff;

    always_comb begin
        q_bit  = (r >= {1'b0, mb});
        diff   = q_bit ? (r - {1'b0, mb}) : r;
        // diff < mb after the restore, so bit 8 is always clear and the shift cannot overflow.
        r_next = {diff[7:0], 1'b0};
    end

endmodule

// File: rtl/bf16_seq_divider.sv
// Iterative BF16 divider (Quotient = A / B) with valid/ready handshakes on both sides.
// Optional round-to-nearest-even is enabled by defining BF16_DIV_RNE_EN; otherwise the result truncates.
//
// state  | meaning
// IDLE   | in_ready high; capture operands, detect special cases
// DIVIDE | ITERS_PER_CYCLE restoring steps per clock, 10 quotient bits total
// NORM   | normalise, optionally round, range-check, register Quotient
// DONE   | present Quotient until out_valid && out_ready
module bf16_seq_divider
    import bf16_pkg::*;
#(
    parameter int ITERS_PER_CYCLE = 1,
    parameter int EXP_BIAS        = EXP_BIAS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Quotient,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [3:0] STEP     = 4'(ITERS_PER_CYCLE);
    localparam logic [3:0] LAST_CNT = 4'(10 - ITERS_PER_CYCLE);

    state_t state, state_nxt;

    logic [7:0] ea_q, eb_q, mb_q;
    logic       sign_q;
    logic [8:0] rem;
    logic [9:0] q;
    logic [3:0] iter_cnt;
    logic       spec_q;
    logic [15:0] spec_res_q;

    bf16_fields_t ua, ub;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic res_sign, is_special;
    logic [15:0] special_res;

    assign ua = bf16_unpack(A);
    assign ub = bf16_unpack(B);

    always_comb begin
        a_zero      = (ua.expn == 8'h00);
        a_inf       = (ua.expn == 8'hFF) && (ua.mant[6:0] == 7'd0);
        a_nan       = (ua.expn == 8'hFF) && (ua.mant[6:0] != 7'd0);
        b_zero      = (ub.expn == 8'h00);
        b_inf       = (ub.expn == 8'hFF) && (ub.mant[6:0] == 7'd0);
        b_nan       = (ub.expn == 8'hFF) && (ub.mant[6:0] != 7'd0);
        res_sign    = ua.sign ^ ub.sign;
        is_special  = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_res = QNAN;
        end else if (b_zero || a_inf) begin
            special_res = {res_sign, POS_INF[14:0]};
        end else if (a_zero || b_inf) begin
            special_res = {res_sign, 15'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    // Restoring-step chain; the first step in the chain produces the more significant bit.
    logic [8:0]                 r_chain [0:ITERS_PER_CYCLE];
    logic [ITERS_PER_CYCLE-1:0] q_chain;
    logic [9:0]                 q_new;

    assign r_chain[0] = rem;

    for (genvar i = 0; i < ITERS_PER_CYCLE; i++) begin : g_step
        bf16_div_step u_step (
            .r      (r_chain[i]),
            .mb     (mb_q),
            .r_next (r_chain[i+1]),
            .q_bit  (q_chain[i])
        );
    end

    always_comb begin
        q_new = q;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            q_new = {q_new[8:0], q_chain[i]};
        end
    end

    logic signed [9:0] exp_pre, exp_adj, exp_fin;
    logic [6:0]        frac, frac_fin;
    logic [15:0]       norm_res;
`ifdef BF16_DIV_RNE_EN
    logic guard, sticky, round_up, carry;
`endif

    always_comb begin
        exp_pre = {2'b00, ea_q} - {2'b00, eb_q} + 10'(EXP_BIAS);
        if (q[9]) begin
            frac    = q[8:2];
            exp_adj = exp_pre;
        end else begin
            frac    = q[7:1];
            exp_adj = exp_pre - 10'sd1;
        end
`ifdef BF16_DIV_RNE_EN
        guard    = q[9] ? q[1] : q[0];
        sticky   = (rem != 9'd0) || (q[9] && q[0]);
        round_up = guard && (sticky || frac[0]);
        {carry, frac_fin} = {1'b0, frac} + {7'd0, round_up};
        exp_fin  = carry ? (exp_adj + 10'sd1) : exp_adj;
`else
        frac_fin = frac;
        exp_fin  = exp_adj;
`endif
        if (exp_fin >= 10'sd255) begin
            norm_res = {sign_q, POS_INF[14:0]};
        end else if (exp_fin <= 10'sd0) begin
            norm_res = {sign_q, 15'd0};
        end else begin
            norm_res = {sign_q, exp_fin[7:0], frac_fin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = is_special ? NORM : DIVIDE;
                end
            end
            DIVIDE: begin
                if (iter_cnt == LAST_CNT) begin
                    state_nxt = NORM;
                end
            end
            NORM:    state_nxt = DONE;
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out_valid comes from a flop that rises one cycle after DONE entry, fixing the
    // handshake-to-valid latency at 10/ITERS_PER_CYCLE + 2 (normal) and 2 (special).
    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q       <= '0;
            eb_q       <= '0;
            mb_q       <= '0;
            sign_q     <= 1'b0;
            rem        <= '0;
            q          <= '0;
            iter_cnt   <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            Quotient   <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        ea_q       <= ua.expn;
                        eb_q       <= ub.expn;
                        mb_q       <= ub.mant;
                        sign_q     <= res_sign;
                        rem        <= {1'b0, ua.mant};
                        q          <= '0;
                        iter_cnt   <= '0;
                        spec_q     <= is_special;
                        spec_res_q <= special_res;
                    end
                end
                DIVIDE: begin
                    rem      <= r_chain[ITERS_PER_CYCLE];
                    q        <= q_new;
                    iter_cnt <= iter_cnt + STEP;
                end
                NORM: begin
                    Quotient <= spec_q ? spec_res_q : norm_res;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bf16_seq_divider.md
Name: bf16_seq_divider

Overview:
- Iterative BFloat16 divider, Quotient = A / B. It is the inverse-operation companion to the combinational approximate BF16 multiplier in the same datapath.
- Uses the same field split (sign, 8-bit exponent, 8-bit explicit mantissa with hidden 1) and the same exception encodings.
- Multi-cycle restoring mantissa division behind valid/ready handshakes on input and output.
- Default result is truncated; round-to-nearest-even is optional.

Parameters:
- ITERS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values: 1 or 2.
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  16  dividend, BF16.
- B  input  16  divisor, BF16.
- in_valid  input  1  A/B are valid.
- in_ready  output  1  block can accept an operand pair.
- Quotient  output  16  BF16 result.
- out_valid  output  1  Quotient is valid.
- out_ready  input  1  consumer accepts Quotient.

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE, in_ready=1, out_valid=0, Quotient=16'h0000, all datapath registers zeroed. Reset in any state aborts the operation in flight; no result is produced.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register operands. Unpack sign, exponent and mantissa (ma, mb = {1, frac}).
  - IDLE special-case detection:
    - Exponent 0 is treated as zero (subnormals flushed).
    - Exponent 255 with fraction 0 is Inf; with fraction nonzero it is NaN.
    - If the result is special, set a special flag and jump straight to NORM.
    - Otherwise load remainder R = {0, ma} (9 bits) and iteration counter = 0, then go to DIVIDE.
  - DIVIDE: in_ready=0. Each cycle perform ITERS_PER_CYCLE restoring steps:
    - if R >= mb then q_bit=1, R = R - mb; else q_bit=0.
    - Then R = R << 1 and shift q_bit into q.
    - Total of 10 quotient bits: q[9] is the integer bit, q[8:0] are fraction bits. Leave after 10/ITERS_PER_CYCLE cycles.
  - NORM (1 cycle):
    - sign = Sa ^ Sb.
    - exp = Ea - Eb + EXP_BIAS, held as a 10-bit signed value.
    - If q[9]=1: frac = q[8:2], guard = q[1], and exp is unchanged.
    - If q[9]=0: frac = q[7:1], guard = q[0], and exp = exp - 1.
    - Sticky = (R != 0) OR the discarded q bit.
    - Apply the optional rounding.
    - Overflow, exp >= 255: Inf with sign.
    - Underflow, exp <= 0: signed zero.
    - Register Quotient and go to DONE.
  - DONE: out_valid=1. Quotient is held stable until out_valid&&out_ready, then go to IDLE with out_valid=0. No new operand is accepted before that cycle.
- Latency: out_valid rises 10/ITERS_PER_CYCLE + 2 cycles after the input handshake edge for a normal divide, and 2 cycles after it for special cases. Throughput is one operation in flight.
- Special results (sign s = Sa ^ Sb):
  - NaN input, 0/0 or Inf/Inf: 16'h7FC0.
  - x/0 with x nonzero: s, Inf (7F80 or FF80).
  - Inf/finite: s, Inf.
  - 0/nonzero or finite/Inf: s, zero.
- in_valid while busy is ignored (in_ready=0). A and B are sampled only at the handshake.

Optional Feature:
- Macro BF16_DIV_RNE_EN.
- Defined: round-to-nearest-even on frac. Round up when guard && (sticky || frac[0]). A mantissa carry-out gives frac=0 and exp+1, and the overflow check runs after rounding.
- Undefined: truncate. guard and sticky are ignored, matching the multiplier's truncation policy. Latency is identical either way.

Decomposition:
- Package bf16_pkg: field-width constants (EXP_W=8, MANT_W=7), the EXP_BIAS default, special encodings (QNAN=16'h7FC0, POS_INF=16'h7F80), a state enum (IDLE, DIVIDE, NORM, DONE), and an unpack function returning sign, exp and {1, frac}.
- One natural sub-module, bf16_div_step: combinational single restoring step. Inputs R and mb; outputs R_next and q_bit. Instantiate it ITERS_PER_CYCLE times in a chain.

Test Plan:
- 16'h3FC0 / 16'h3F80 (1.5/1.0), out_ready=1, ITERS_PER_CYCLE=1 -> Quotient=16'h3FC0; out_valid exactly 12 cycles after handshake.
- 16'h3F80 / 16'h4040 (1/3) -> 16'h3EAA without macro, 16'h3EAB with BF16_DIV_RNE_EN.
- Specials:
  - 16'hC000 / 16'h0000 -> 16'hFF80.
  - 16'h0000 / 16'h0000 -> 16'h7FC0.
  - 16'h4000 / 16'h7F80 -> 16'h0000.
  - Each gives out_valid 2 cycles after handshake.
- 16'h7F00 / 16'h0080 -> 16'h7F80 (overflow). 16'h0080 / 16'h7F00 -> 16'h0000 (underflow).
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Quotient stays stable, in_ready=0, and a second in_valid pulse is ignored. Release -> exactly one transfer, then IDLE.
- Assert rst on the 4th DIVIDE cycle -> next cycle in IDLE, out_valid=0, Quotient=0. A following divide of 16'h4000 / 16'h4000 -> 16'h3F80.
